hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the hold input of the IF/ID register (nop_lock_id), the PC write enable, the ID/EX bubble and the wrong-path IF/ID flush. It resolves four hazard sources:
- load-use
- multi-cycle MULT/DIV occupancy
- data-memory wait
- taken branch/jump

It also keeps a stall-cycle performance counter.

Parameters:
MULT_CYCLES, 4, EX-occupancy cycles of MULT/MULTU after issue (>=1)
DIV_CYCLES, 32, EX-occupancy cycles of DIV/DIVU after issue (>=1)
CNT_W, 6, width of MD down-counter; must hold max(MULT_CYCLES, DIV_CYCLES)
PERF_W, 32, width of stall performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
rs_id  in  5  rs field of instruction in ID
rt_id  in  5  rt field of instruction in ID
uses_rs_id  in  1  ID instruction reads rs
uses_rt_id  in  1  ID instruction reads rt
mem_read_ex  in  1  EX instruction is a load
rd_ex  in  5  destination register of EX instruction
md_start_id  in  1  ID instruction is MULT/MULTU/DIV/DIVU
md_is_div_id  in  1  qualifies md_start_id: 1 = divide
md_read_id  in  1  ID instruction is MFHI/MFLO
pc_bj  in  1  branch taken / jump resolved in ID
dmem_req_mem  in  1  MEM stage has an active data access
dmem_ready  in  1  data memory completes access this cycle
pc_write_en  out  1  PC may update
nop_lock_id  out  1  hold IF/ID register
flush_if_id  out  1  load NOP into IF/ID
bubble_id_ex  out  1  load NOP into ID/EX
freeze_all  out  1  hold ID/EX, EX/MEM, MEM/WB
md_busy  out  1  MULT/DIV unit occupied
md_done  out  1  one-cycle pulse: HI/LO valid
stall_count  out  PERF_W  cycles with nop_lock_id=1, saturating

Behaviour:
- Reset (async, while rst=1):
  - pc_write_en=0, nop_lock_id=1, flush_if_id=1, bubble_id_ex=1, freeze_all=0
  - md_busy=0, md_done=0, stall_count=0
  - MD FSM=MD_IDLE, counter=0
  - First cycle after deassertion is normal RUN.
- Hazard terms (combinational, same cycle):
  - mem_wait = dmem_req_mem & ~dmem_ready
  - load_use = mem_read_ex & rd_ex!=0 & ((uses_rs_id & rs_id==rd_ex) | (uses_rt_id & rt_id==rd_ex))
  - md_hazard = md_busy & (md_start_id | md_read_id)
- Priority and outputs (first true wins):
  1. mem_wait: freeze_all=1, nop_lock_id=1, pc_write_en=0, bubble_id_ex=0, flush_if_id=0. MD counter still decrements (unit is independent).
  2. load_use: nop_lock_id=1, pc_write_en=0, bubble_id_ex=1. Exactly 1 cycle per hazard occurrence.
  3. md_hazard: same as load_use; repeats every cycle until md_busy falls.
  4. pc_bj: flush_if_id=1, pc_write_en=1, nop_lock_id=0.
  5. Else: pc_write_en=1, all others 0.
- A branch in ID during a stall is not flushed. ID is held, pc_bj is re-presented, and the flush occurs on the first unstalled cycle.
- MD FSM:
  - MD_IDLE: on md_start_id & no stall term active (issue accepted), load counter with DIV_CYCLES-1 or MULT_CYCLES-1 and go to MD_BUSY.
  - MD_BUSY: md_busy=1; counter decrements each cycle. At counter==0, go to MD_DONE.
  - MD_DONE: md_done=1 for exactly this cycle, md_busy=0. A new issue accepted in this cycle goes directly to MD_BUSY; otherwise go to MD_IDLE.
  - An issue is accepted only when not stalled, so no issue ever occurs while busy.
- Latency: MULT issued cycle T gives md_busy=1 for T+1..T+MULT_CYCLES-1 and md_done at T+MULT_CYCLES. MFHI in ID is released in the md_done cycle.
- Edge cases:
  - With MULT_CYCLES=1, go directly to MD_DONE the cycle after issue.
  - rst mid-operation aborts MD. No md_done is emitted.
  - stall_count increments on every cycle with nop_lock_id=1 (excluding reset) and saturates at all-ones.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - md_state_t enum {MD_IDLE, MD_BUSY, MD_DONE}
  - REG_ZERO=5'd0
  - default cycle constants
- Sub-module md_occupancy (MD FSM + down-counter) is natural.
- Hazard priority logic stays flat in hazard_ctrl.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=8, rs_id=8, uses_rs_id=1 -> one cycle with nop_lock_id=1, bubble_id_ex=1, pc_write_en=0. Repeat with rd_ex=0 -> no stall.
- MULT then MFHI: issue MULT at T, MFHI in ID at T+1 -> stalled T+1..T+3, md_done=1 at T+4, nop_lock_id=0 at T+4, stall_count=3.
- DIV back-to-back: DIV at T, DIV in ID at T+1 -> second accepted at T+32 (md_done cycle), md_busy=1 again T+33..T+63.
- Mem wait during load_use and pc_bj: dmem_req_mem=1, dmem_ready=0 for 3 cycles -> freeze_all=1, bubble_id_ex=0, flush_if_id=0 for 3 cycles. Then the load_use stall fires, then the flush.
- Branch: pc_bj=1, no hazards -> flush_if_id=1, pc_write_en=1 same cycle. pc_bj with load_use -> flush delayed exactly 1 cycle.
- Async reset at T+10 of a DIV: rst pulse mid-cycle -> md_busy=0 and stall_count=0 immediately, no md_done afterwards.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default constants for the pipeline control slice.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam int CNT_W_DEF       = 6;
    localparam int PERF_W_DEF      = 32;

endpackage

// File: rtl/hazard_ctrl_md_occupancy.sv
// MULT/DIV occupancy tracker: IDLE -> BUSY (down-count) -> DONE, one DONE cycle per operation.
module md_occupancy
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_i,
    input  logic      is_div_i,
    output md_state_t state_o
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;

    assign load_val = is_div_i ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The DONE cycle accepts a new issue, so back-to-back operations skip IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
                if (issue_i) begin
                    cnt_d   = load_val;
                    state_d = (load_val == '0) ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = MD_DONE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        state_o = state_q;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritises mem wait, load-use, MD hazard, branch flush.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PERF_W      = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs_id,
    input  logic [4:0]        rt_id,
    input  logic              uses_rs_id,
    input  logic              uses_rt_id,
    input  logic              mem_read_ex,
    input  logic [4:0]        rd_ex,
    input  logic              md_start_id,
    input  logic              md_is_div_id,
    input  logic              md_read_id,
    input  logic              pc_bj,
    input  logic              dmem_req_mem,
    input  logic              dmem_ready,
    output logic              pc_write_en,
    output logic              nop_lock_id,
    output logic              flush_if_id,
    output logic              bubble_id_ex,
    output logic              freeze_all,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_count
);

    logic              mem_wait;
    logic              load_use;
    logic              md_hazard;
    logic              md_issue;
    md_state_t         md_state;
    logic [PERF_W-1:0] stall_count_q;

    assign mem_wait  = dmem_req_mem & ~dmem_ready;
    assign load_use  = mem_read_ex & (rd_ex != REG_ZERO)
                     & ((uses_rs_id & (rs_id == rd_ex)) | (uses_rt_id & (rt_id == rd_ex)));
    assign md_busy   = (md_state == MD_BUSY);
    assign md_done   = (md_state == MD_DONE);
    assign md_hazard = md_busy & (md_start_id | md_read_id);
    assign md_issue  = md_start_id & ~(mem_wait | load_use | md_hazard);

    md_occupancy #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk     (clk),
        .rst     (rst),
        .issue_i (md_issue),
        .is_div_i(md_is_div_id),
        .state_o (md_state)
    );

    // A branch seen during any stall is simply held in ID and flushed once the stall clears.
    always_comb begin
        pc_write_en  = 1'b1;
        nop_lock_id  = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        freeze_all   = 1'b0;
        if (rst) begin
            pc_write_en  = 1'b0;
            nop_lock_id  = 1'b1;
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (mem_wait) begin
            freeze_all  = 1'b1;
            nop_lock_id = 1'b1;
            pc_write_en = 1'b0;
        end else if (load_use | md_hazard) begin
            nop_lock_id  = 1'b1;
            pc_write_en  = 1'b0;
            bubble_id_ex = 1'b1;
        end else if (pc_bj) begin
            flush_if_id = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (nop_lock_id && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign stall_count = stall_count_q;

endmodule
